// File: rtl/redmule_job_queue.sv
// Job-context queue: host acquires/programs/commits slots, engine consumes them in FIFO order.
// Latency: acquire response, read data and job-end event one cycle after the request; writes visible next cycle.
// Backpressure: engine pulls jobs with job_valid_o/job_ready_i; a full queue refuses acquires (acq_ok_o=0).
module redmule_job_queue #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_REGS    = 19,
    parameter int unsigned ID_W      = 8,
    localparam int unsigned AW = $clog2(N_REGS),
    localparam int unsigned PW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
    localparam int unsigned NW = $clog2(N_CONTEXT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [AW-1:0]        cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    input  logic [3:0]           cfg_be_i,
    output logic                 cfg_gnt_o,
    output logic [31:0]          cfg_rdata_o,
    output logic                 cfg_rvalid_o,
    input  logic                 acquire_i,
    input  logic                 commit_i,
    output logic                 acq_valid_o,
    output logic                 acq_ok_o,
    output logic [ID_W-1:0]      acq_id_o,
    output logic                 job_valid_o,
    input  logic                 job_ready_i,
    output logic [N_REGS*32-1:0] job_regs_o,
    output logic [ID_W-1:0]      job_id_o,
    input  logic                 done_i,
    output logic                 evt_o,
    output logic                 busy_o,
    output logic [NW-1:0]        n_used_o
);

    typedef enum logic [1:0] {
        S_FREE = 2'd0,
        S_ACQ  = 2'd1,
        S_COMM = 2'd2,
        S_RUN  = 2'd3
    } slot_state_e;

    slot_state_e       state_q [N_CONTEXT];
    slot_state_e       state_d [N_CONTEXT];
    logic [ID_W-1:0]   ids_q   [N_CONTEXT];
    logic [ID_W-1:0]   ids_d   [N_CONTEXT];
    logic [31:0]       regs_q  [N_CONTEXT][N_REGS];
    logic [31:0]       regs_d  [N_CONTEXT][N_REGS];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
    logic [NW-1:0]     n_used_q, n_used_d;
    logic              acq_valid_q, acq_valid_d;
    logic              acq_ok_q, acq_ok_d;
    logic [ID_W-1:0]   acq_id_q, acq_id_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              evt_q, evt_d;

    logic has_acq, busy, job_valid, addr_ok;
    logic alloc, commit_fire, start_fire, done_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_CONTEXT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Event decode, all evaluated against the registered state of this cycle.
    always_comb begin
        // The only slot that can be ACQUIRED is the one wr_ptr points at.
        has_acq     = (state_q[wr_ptr_q] == S_ACQ);
        busy        = (state_q[rd_ptr_q] == S_RUN);
        job_valid   = (state_q[rd_ptr_q] == S_COMM);
        addr_ok     = (32'(cfg_addr_i) < N_REGS);
        alloc       = acquire_i && !has_acq && (n_used_q < NW'(N_CONTEXT));
        commit_fire = commit_i && has_acq;
        start_fire  = job_valid && job_ready_i;
        done_fire   = done_i && busy;
    end

    // Next-state for slots, pointers, register file and response strobes.
    always_comb begin
        state_d     = state_q;
        ids_d       = ids_q;
        regs_d      = regs_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        id_cnt_d    = id_cnt_q;
        n_used_d    = n_used_q;
        acq_valid_d = acquire_i;
        acq_ok_d    = has_acq || alloc;
        acq_id_d    = has_acq ? ids_q[wr_ptr_q] : id_cnt_q;
        rvalid_d    = cfg_req_i && !cfg_we_i;
        rdata_d     = '0;
        evt_d       = done_fire;

        if (rvalid_d && addr_ok) begin
            rdata_d = has_acq ? regs_q[wr_ptr_q][cfg_addr_i] : regs_q[rd_ptr_q][cfg_addr_i];
        end

        if (cfg_req_i && cfg_we_i && has_acq && addr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cfg_be_i[b]) begin
                    regs_d[wr_ptr_q][cfg_addr_i][8*b +: 8] = cfg_wdata_i[8*b +: 8];
                end
            end
        end

        // alloc/commit are mutually exclusive (has_acq), as are start/done (slot state).
        if (alloc) begin
            state_d[wr_ptr_q] = S_ACQ;
            ids_d[wr_ptr_q]   = id_cnt_q;
            id_cnt_d          = id_cnt_q + ID_W'(1);
        end
        if (commit_fire) begin
            state_d[wr_ptr_q] = S_COMM;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (start_fire) begin
            state_d[rd_ptr_q] = S_RUN;
        end
        if (done_fire) begin
            state_d[rd_ptr_q] = S_FREE;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end

        if (alloc && !done_fire) begin
            n_used_d = n_used_q + NW'(1);
        end else if (done_fire && !alloc) begin
            n_used_d = n_used_q - NW'(1);
        end

        // Soft clear returns everything to the reset image.
        if (clear_i) begin
            for (int s = 0; s < N_CONTEXT; s++) begin
                state_d[s] = S_FREE;
                ids_d[s]   = '0;
                for (int r = 0; r < N_REGS; r++) begin
                    regs_d[s][r] = '0;
                end
            end
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            id_cnt_d    = '0;
            n_used_d    = '0;
            acq_valid_d = 1'b0;
            acq_ok_d    = 1'b0;
            acq_id_d    = '0;
            rvalid_d    = 1'b0;
            rdata_d     = '0;
            evt_d       = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < N_CONTEXT; s++) begin
                state_q[s] <= S_FREE;
                ids_q[s]   <= '0;
                for (int r = 0; r < N_REGS; r++) begin
                    regs_q[s][r] <= '0;
                end
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            id_cnt_q    <= '0;
            n_used_q    <= '0;
            acq_valid_q <= 1'b0;
            acq_ok_q    <= 1'b0;
            acq_id_q    <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            evt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ids_q       <= ids_d;
            regs_q      <= regs_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            id_cnt_q    <= id_cnt_d;
            n_used_q    <= n_used_d;
            acq_valid_q <= acq_valid_d;
            acq_ok_q    <= acq_ok_d;
            acq_id_q    <= acq_id_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            evt_q       <= evt_d;
        end
    end

    // Output mapping; the head slot's register set is presented flat.
    always_comb begin
        job_regs_o = '0;
        for (int k = 0; k < N_REGS; k++) begin
            job_regs_o[32*k +: 32] = regs_q[rd_ptr_q][k];
        end
        cfg_gnt_o    = cfg_req_i;
        cfg_rdata_o  = rdata_q;
        cfg_rvalid_o = rvalid_q;
        acq_valid_o  = acq_valid_q;
        acq_ok_o     = acq_ok_q && acq_valid_q;
        acq_id_o     = acq_valid_q ? acq_id_q : '0;
        job_valid_o  = job_valid;
        job_id_o     = ids_q[rd_ptr_q];
        evt_o        = evt_q;
        busy_o       = busy;
        n_used_o     = n_used_q;
    end

endmodule

// File: tb/tb_redmule_job_queue.sv
// Directed bench for redmule_job_queue with three slots and a response scoreboard.
// Latency: every check is sampled 1 time unit after the edge that follows the stimulus.
// Backpressure: engine side driven explicitly with job_ready_i/done_i pulses.
module tb_redmule_job_queue;

    localparam int NC = 3;
    localparam int NR = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_i, cfg_req_i, cfg_we_i;
    logic [4:0]    cfg_addr_i;
    logic [31:0]   cfg_wdata_i;
    logic [3:0]    cfg_be_i;
    logic          cfg_gnt_o;
    logic [31:0]   cfg_rdata_o;
    logic          cfg_rvalid_o;
    logic          acquire_i, commit_i;
    logic          acq_valid_o, acq_ok_o;
    logic [7:0]    acq_id_o;
    logic          job_valid_o, job_ready_i;
    logic [NR*32-1:0] job_regs_o;
    logic [7:0]    job_id_o;
    logic          done_i, evt_o, busy_o;
    logic [1:0]    n_used_o;

    typedef struct packed {
        logic       ok;
        logic [7:0] id;
    } acq_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [4:0]  idx;
        logic [31:0] val;
    } job_t;

    acq_t        acq_q[$];
    job_t        job_q[$];
    logic [31:0] rd_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    redmule_job_queue #(.N_CONTEXT(NC), .N_REGS(NR), .ID_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_be_i(cfg_be_i), .cfg_gnt_o(cfg_gnt_o),
        .cfg_rdata_o(cfg_rdata_o), .cfg_rvalid_o(cfg_rvalid_o),
        .acquire_i(acquire_i), .commit_i(commit_i),
        .acq_valid_o(acq_valid_o), .acq_ok_o(acq_ok_o), .acq_id_o(acq_id_o),
        .job_valid_o(job_valid_o), .job_ready_i(job_ready_i),
        .job_regs_o(job_regs_o), .job_id_o(job_id_o),
        .done_i(done_i), .evt_o(evt_o), .busy_o(busy_o), .n_used_o(n_used_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return job_regs_o[32*k +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acquire(input logic ok, input logic [7:0] id);
        acq_t e;
        acq_q.push_back({ok, id});
        acquire_i = 1'b1;
        tick();
        acquire_i = 1'b0;
        e = acq_q.pop_front();
        chk("acq_valid", acq_valid_o, 1);
        chk("acq_ok", acq_ok_o, e.ok);
        if (e.ok) chk("acq_id", acq_id_o, e.id);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d; cfg_be_i = be;
        tick();
        cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
        tick();
        cfg_req_i = 1'b0;
        chk("rvalid", cfg_rvalid_o, 1);
        chk("rdata", cfg_rdata_o, rd_q.pop_front());
    endtask

    task automatic commit();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
    endtask

    task automatic expect_head();
        job_t j;
        j = job_q.pop_front();
        chk("job_valid", job_valid_o, 1);
        chk("job_id", job_id_o, j.id);
        chk("job_word", word(int'(j.idx)), j.val);
    endtask

    task automatic start();
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
        chk("busy_on_start", busy_o, 1);
        chk("valid_off_start", job_valid_o, 0);
    endtask

    task automatic finish_job();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("evt_pulse", evt_o, 1);
        chk("busy_off", busy_o, 0);
        tick();
        chk("evt_one_cycle", evt_o, 0);
    endtask

    initial begin
        rst_n = 1'b0; clear_i = 1'b0; cfg_req_i = 1'b0; cfg_we_i = 1'b0;
        cfg_addr_i = '0; cfg_wdata_i = '0; cfg_be_i = '0;
        acquire_i = 1'b0; commit_i = 1'b0; job_ready_i = 1'b0; done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_job_valid", job_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_n_used", n_used_o, 0);
        chk("rst_evt", evt_o, 0);
        chk("rst_acq_valid", acq_valid_o, 0);
        chk("rst_rvalid", cfg_rvalid_o, 0);
        chk("rst_job_regs_zero", |job_regs_o, 0);
        chk("rst_job_id", job_id_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic job
        acquire(1'b1, 8'd0);
        wr(5'd18, 32'h1, 4'hF);
        job_q.push_back({8'd0, 5'd18, 32'h1});
        commit();
        expect_head();
        chk("n_used_1", n_used_o, 1);
        start();
        finish_job();
        chk("n_used_0", n_used_o, 0);

        // Byte enables, range, ordering
        acquire(1'b1, 8'd1);
        wr(5'd0, 32'hAABBCCDD, 4'b0101);
        rd(5'd0, 32'h00BB00DD);
        wr(5'd19, 32'hFFFFFFFF, 4'hF);
        rd(5'd19, 32'h0);
        wr(5'd0, 32'h100, 4'hF);
        job_q.push_back({8'd1, 5'd0, 32'h100});
        commit();
        acquire(1'b1, 8'd2);
        wr(5'd0, 32'h200, 4'hF);
        job_q.push_back({8'd2, 5'd0, 32'h200});
        commit();
        chk("n_used_2", n_used_o, 2);
        expect_head();
        start();
        chk("head_held_while_busy", word(0), 32'h100);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("evt_A", evt_o, 1);
        expect_head();
        start();
        finish_job();

        // Full queue
        acquire(1'b1, 8'd3); commit();
        acquire(1'b1, 8'd4); commit();
        acquire(1'b1, 8'd5); commit();
        chk("n_used_full", n_used_o, 3);
        acquire(1'b0, 8'd0);
        job_q.push_back({8'd3, 5'd18, 32'h1});
        expect_head();
        start();
        finish_job();
        acquire(1'b1, 8'd6);
        rd(5'd18, 32'h1);
        chk("n_used_refill", n_used_o, 3);
        commit();

        // Done + acquire on a full queue
        job_q.push_back({8'd4, 5'd0, 32'h100});
        expect_head();
        start();
        acq_q.push_back({1'b0, 8'd0});
        done_i = 1'b1; acquire_i = 1'b1;
        tick();
        done_i = 1'b0; acquire_i = 1'b0;
        chk("evt_full_done", evt_o, 1);
        chk("acq_valid_full", acq_valid_o, 1);
        chk("acq_ok_full", acq_ok_o, acq_q.pop_front().ok);
        chk("n_used_after", n_used_o, 2);

        // Done without busy
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("evt_no_busy", evt_o, 0);
        chk("n_used_no_busy", n_used_o, 2);
        job_q.push_back({8'd5, 5'd0, 32'h200});
        expect_head();
        start();
        finish_job();
        job_q.push_back({8'd6, 5'd18, 32'h1});
        expect_head();
        start();
        finish_job();
        chk("n_used_empty", n_used_o, 0);

        // Commit without acquire
        commit();
        chk("commit_ignored_valid", job_valid_o, 0);
        chk("commit_ignored_used", n_used_o, 0);

        // Commit and acquire together
        acquire(1'b1, 8'd7);
        acq_q.push_back({1'b1, 8'd7});
        commit_i = 1'b1; acquire_i = 1'b1;
        tick();
        commit_i = 1'b0; acquire_i = 1'b0;
        chk("ca_ok", acq_ok_o, acq_q[0].ok);
        chk("ca_id", acq_id_o, acq_q.pop_front().id);
        job_q.push_back({8'd7, 5'd0, 32'h100});
        expect_head();
        chk("ca_n_used", n_used_o, 1);
        acquire(1'b1, 8'd8);
        commit();
        start();
        finish_job();
        job_q.push_back({8'd8, 5'd0, 32'h200});
        expect_head();
        start();
        finish_job();

        // ID counter wrap
        for (int i = 9; i < 256; i++) begin
            acquire(1'b1, 8'(i));
            commit();
            job_ready_i = 1'b1;
            tick();
            job_ready_i = 1'b0;
            done_i = 1'b1;
            tick();
            done_i = 1'b0;
        end
        acquire(1'b1, 8'd0);
        commit();
        start();
        finish_job();

        // Async reset mid-run
        acquire(1'b1, 8'd1); commit();
        start();
        acquire(1'b1, 8'd2); commit();
        acquire(1'b1, 8'd3); commit();
        chk("pre_rst_used", n_used_o, 3);
        chk("pre_rst_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_n_used", n_used_o, 0);
        chk("arst_job_valid", job_valid_o, 0);
        chk("arst_job_regs", |job_regs_o, 0);
        chk("arst_job_id", job_id_o, 0);
        chk("arst_evt", evt_o, 0);
        tick();
        chk("arst_evt_held", evt_o, 0);
        rst_n = 1'b1;
        tick();
        acquire(1'b1, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
